fpu_ss_issue_buffer: RTL and testbench

- Instruction input FIFO of the FPU subsystem. It accepts offloaded instructions and their source operands from the core-side issue handshake.
- It presents the oldest live entry to the FPU subsystem controller through the in_buf pop handshake.
- It silently drops entries whose id receives a commit kill, so killed instructions are never presented to the controller.
- Sits directly upstream of the controller, which consumes pop_valid/pop_ready and the head entry fields.

---
 rtl/fpu_ss_issue_buffer.sv | 157 +++++++++++++++
 tb/tb_fpu_ss_issue_buffer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_ss_issue_buffer.sv
// Issue buffer of the FPU subsystem: a small in-order FIFO of offloaded
// instructions and their integer operands. Entries hit by a commit kill are
// flagged and silently dropped when they reach the head, so the controller
// only ever sees live instructions. Optional fall-through lets an empty
// buffer hand the incoming instruction straight to the controller.
module fpu_ss_issue_buffer #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned ID_WIDTH     = 4,
  parameter bit          FALL_THROUGH = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic [31:0]                issue_instr_i,
  input  logic [ID_WIDTH-1:0]        issue_id_i,
  input  logic [31:0]                issue_rs0_i,
  input  logic [31:0]                issue_rs1_i,
  input  logic [31:0]                issue_rs2_i,
  input  logic                       commit_valid_i,
  input  logic [ID_WIDTH-1:0]        commit_id_i,
  input  logic                       commit_kill_i,
  output logic                       in_buf_pop_valid_o,
  input  logic                       in_buf_pop_ready_i,
  output logic [31:0]                pop_instr_o,
  output logic [ID_WIDTH-1:0]        pop_id_o,
  output logic [31:0]                pop_rs0_o,
  output logic [31:0]                pop_rs1_o,
  output logic [31:0]                pop_rs2_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DEPTH-1:0]    killed_q, killed_d;
  logic [31:0]         instr_q [DEPTH];
  logic [31:0]         instr_d [DEPTH];
  logic [ID_WIDTH-1:0] id_q    [DEPTH];
  logic [ID_WIDTH-1:0] id_d    [DEPTH];
  logic [31:0]         rs0_q   [DEPTH];
  logic [31:0]         rs0_d   [DEPTH];
  logic [31:0]         rs1_q   [DEPTH];
  logic [31:0]         rs1_d   [DEPTH];
  logic [31:0]         rs2_q   [DEPTH];
  logic [31:0]         rs2_d   [DEPTH];

  logic empty, full, kill_en, issue_killed, bypass;
  logic pop_valid, head_remove, push;

  // Handshake decode: ready depends on stored state only; a killed head is
  // dropped whether or not the controller is ready.
  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == CNT_W'(DEPTH));
    kill_en      = commit_valid_i & commit_kill_i;
    issue_killed = kill_en & (commit_id_i == issue_id_i);
    bypass       = FALL_THROUGH & empty;
    if (bypass) begin
      pop_valid = issue_valid_i & ~issue_killed;
    end else begin
      pop_valid = ~empty & ~killed_q[rd_ptr_q];
    end
    head_remove = ~empty & (killed_q[rd_ptr_q] | in_buf_pop_ready_i);
    // A bypassed instruction that is consumed immediately is never stored.
    push        = issue_valid_i & ~full & ~(bypass & pop_valid & in_buf_pop_ready_i);
  end

  // Next-state: kill marking of occupied slots, head removal, then tail write.
  always_comb begin
    logic [PTR_W-1:0] offs;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    killed_d = killed_q;
    instr_d  = instr_q;
    id_d     = id_q;
    rs0_d    = rs0_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    offs     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = PTR_W'(i) - rd_ptr_q;
      if (kill_en && (id_q[i] == commit_id_i) && (CNT_W'(offs) < count_q)) begin
        killed_d[i] = 1'b1;
      end
    end
    if (head_remove) begin
      killed_d[rd_ptr_q] = 1'b0;
      rd_ptr_d           = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      instr_d[wr_ptr_q]  = issue_instr_i;
      id_d[wr_ptr_q]     = issue_id_i;
      rs0_d[wr_ptr_q]    = issue_rs0_i;
      rs1_d[wr_ptr_q]    = issue_rs1_i;
      rs2_d[wr_ptr_q]    = issue_rs2_i;
      killed_d[wr_ptr_q] = issue_killed;
      wr_ptr_d           = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(head_remove);
  end

  // State registers; reset clears control and storage at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      killed_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        id_q[i]    <= '0;
        rs0_q[i]   <= '0;
        rs1_q[i]   <= '0;
        rs2_q[i]   <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      killed_q <= killed_d;
      instr_q  <= instr_d;
      id_q     <= id_d;
      rs0_q    <= rs0_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
    end
  end

  // Head outputs: the incoming instruction while bypassing, else the stored head.
  always_comb begin
    issue_ready_o      = ~full;
    in_buf_pop_valid_o = pop_valid;
    count_o            = count_q;
    full_o             = full;
    empty_o            = empty;
    if (bypass) begin
      pop_instr_o = issue_instr_i;
      pop_id_o    = issue_id_i;
      pop_rs0_o   = issue_rs0_i;
      pop_rs1_o   = issue_rs1_i;
      pop_rs2_o   = issue_rs2_i;
    end else begin
      pop_instr_o = instr_q[rd_ptr_q];
      pop_id_o    = id_q[rd_ptr_q];
      pop_rs0_o   = rs0_q[rd_ptr_q];
      pop_rs1_o   = rs1_q[rd_ptr_q];
      pop_rs2_o   = rs2_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_fpu_ss_issue_buffer.sv
// Bench for fpu_ss_issue_buffer: one registered instance and one
// fall-through instance share the same stimulus and are each compared
// against an ordered-list reference model of the buffer contents.
module tb_fpu_ss_issue_buffer;

  localparam int DEPTH = 4;
  localparam int IDW   = 4;

  typedef struct packed {
    logic [31:0]    instr;
    logic [IDW-1:0] id;
    logic [31:0]    rs0;
    logic [31:0]    rs1;
    logic [31:0]    rs2;
    logic           killed;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           iv, cv, ck, pr;
  logic [31:0]    instr, rs0, rs1, rs2;
  logic [IDW-1:0] iid, cid;

  logic           ir0, pv0, full0, empty0;
  logic [IDW-1:0] pid0;
  logic [31:0]    pin0, pa0, pb0, pc0;
  logic [2:0]     cnt0;
  logic           ir1, pv1, full1, empty1;
  logic [IDW-1:0] pid1;
  logic [31:0]    pin1, pa1, pb1, pc1;
  logic [2:0]     cnt1;

  fpu_ss_issue_buffer #(.DEPTH(DEPTH), .ID_WIDTH(IDW), .FALL_THROUGH(1'b0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_valid_i(iv), .issue_ready_o(ir0), .issue_instr_i(instr), .issue_id_i(iid),
    .issue_rs0_i(rs0), .issue_rs1_i(rs1), .issue_rs2_i(rs2),
    .commit_valid_i(cv), .commit_id_i(cid), .commit_kill_i(ck),
    .in_buf_pop_valid_o(pv0), .in_buf_pop_ready_i(pr),
    .pop_instr_o(pin0), .pop_id_o(pid0), .pop_rs0_o(pa0), .pop_rs1_o(pb0), .pop_rs2_o(pc0),
    .count_o(cnt0), .full_o(full0), .empty_o(empty0)
  );

  fpu_ss_issue_buffer #(.DEPTH(DEPTH), .ID_WIDTH(IDW), .FALL_THROUGH(1'b1)) u_dut_ft (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_valid_i(iv), .issue_ready_o(ir1), .issue_instr_i(instr), .issue_id_i(iid),
    .issue_rs0_i(rs0), .issue_rs1_i(rs1), .issue_rs2_i(rs2),
    .commit_valid_i(cv), .commit_id_i(cid), .commit_kill_i(ck),
    .in_buf_pop_valid_o(pv1), .in_buf_pop_ready_i(pr),
    .pop_instr_o(pin1), .pop_id_o(pid1), .pop_rs0_o(pa1), .pop_rs1_o(pb1), .pop_rs2_o(pc1),
    .count_o(cnt1), .full_o(full1), .empty_o(empty1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, want, $time);
    end
  endtask

  // Reference model: per instance, an ordered list with the oldest entry at index 0.
  entry_t mdl [2][DEPTH];
  int     sz  [2];

  task automatic model_check(input int m);
    bit     ft, emp, kill_iss, e_pv;
    entry_t head;
    logic           o_ir, o_pv, o_full, o_empty;
    logic [IDW-1:0] o_id;
    logic [31:0]    o_instr, o_rs0, o_rs1, o_rs2;
    logic [2:0]     o_cnt;
    ft       = (m == 1);
    emp      = (sz[m] == 0);
    kill_iss = cv && ck && (cid == iid);
    if (ft && emp) begin
      e_pv = iv && !kill_iss;
      head = '{instr, iid, rs0, rs1, rs2, 1'b0};
    end else begin
      e_pv = !emp && !mdl[m][0].killed;
      head = mdl[m][0];
    end
    if (m == 0) begin
      o_ir = ir0; o_pv = pv0; o_full = full0; o_empty = empty0; o_id = pid0;
      o_instr = pin0; o_rs0 = pa0; o_rs1 = pb0; o_rs2 = pc0; o_cnt = cnt0;
    end else begin
      o_ir = ir1; o_pv = pv1; o_full = full1; o_empty = empty1; o_id = pid1;
      o_instr = pin1; o_rs0 = pa1; o_rs1 = pb1; o_rs2 = pc1; o_cnt = cnt1;
    end
    check_eq($sformatf("u%0d.count", m), o_cnt, sz[m]);
    check_eq($sformatf("u%0d.full", m), o_full, sz[m] == DEPTH);
    check_eq($sformatf("u%0d.empty", m), o_empty, emp);
    check_eq($sformatf("u%0d.issue_ready", m), o_ir, sz[m] < DEPTH);
    check_eq($sformatf("u%0d.pop_valid", m), o_pv, e_pv);
    if (e_pv) begin
      check_eq($sformatf("u%0d.pop_id", m), o_id, head.id);
      check_eq($sformatf("u%0d.pop_instr", m), o_instr, head.instr);
      check_eq($sformatf("u%0d.pop_rs0", m), o_rs0, head.rs0);
      check_eq($sformatf("u%0d.pop_rs1", m), o_rs1, head.rs1);
      check_eq($sformatf("u%0d.pop_rs2", m), o_rs2, head.rs2);
    end
  endtask

  task automatic model_update(input int m);
    bit ft, emp, kill_en, kill_iss, e_pv, remove, push;
    ft       = (m == 1);
    emp      = (sz[m] == 0);
    kill_en  = cv && ck;
    kill_iss = kill_en && (cid == iid);
    e_pv     = (ft && emp) ? (iv && !kill_iss) : (!emp && !mdl[m][0].killed);
    remove   = !emp && (mdl[m][0].killed || pr);
    push     = iv && (sz[m] < DEPTH) && !(ft && emp && e_pv && pr);
    if (kill_en)
      for (int i = 0; i < sz[m]; i++)
        if (mdl[m][i].id == cid) mdl[m][i].killed = 1'b1;
    if (remove) begin
      for (int i = 0; i < sz[m] - 1; i++) mdl[m][i] = mdl[m][i+1];
      sz[m]--;
    end
    if (push) begin
      mdl[m][sz[m]] = '{instr, iid, rs0, rs1, rs2, kill_iss};
      sz[m]++;
    end
  endtask

  task automatic drive(input bit v, input logic [IDW-1:0] id, input bit r,
                       input bit c, input bit k, input logic [IDW-1:0] c_id);
    @(negedge clk);
    iv = v; iid = id; pr = r; cv = c; ck = k; cid = c_id;
    instr = $urandom; rs0 = $urandom; rs1 = $urandom; rs2 = $urandom;
    #1;
  endtask

  task automatic tick();
    model_check(0);
    model_check(1);
    @(posedge clk);
    if (rst_n) begin
      model_update(0);
      model_update(1);
    end
  endtask

  task automatic step(input bit v, input logic [IDW-1:0] id, input bit r,
                      input bit c, input bit k, input logic [IDW-1:0] c_id);
    drive(v, id, r, c, k, c_id);
    tick();
  endtask

  logic [31:0] saved;

  initial begin
    rst_n = 1'b0;
    iv = 0; iid = '0; pr = 0; cv = 0; ck = 0; cid = '0;
    instr = '0; rs0 = '0; rs1 = '0; rs2 = '0;
    sz[0] = 0; sz[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_eq("reset.count", cnt0, 0);
    check_eq("reset.empty", empty0, 1);
    check_eq("reset.full", full0, 0);
    check_eq("reset.issue_ready", ir0, 1);
    check_eq("reset.pop_valid", pv0, 0);
    check_eq("reset.pop_id", pid0, 0);
    check_eq("reset.pop_instr", pin0, 0);
    check_eq("reset.pop_rs0", pa0, 0);
    @(negedge clk); rst_n = 1'b1;

    // Fill to full, then offer a fifth instruction that must be refused.
    for (int i = 1; i <= 5; i++) step(1'b1, IDW'(i), 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    check_eq("fill.count", cnt0, 4);
    check_eq("fill.full", full0, 1);
    check_eq("fill.issue_ready", ir0, 0);
    check_eq("fill.pop_id", pid0, 1);
    tick();
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);

    // Steady stream at occupancy two.
    step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 3; i < 13; i++) step(1'b1, IDW'(i), 1'b1, 1'b0, 1'b0, '0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    check_eq("stream.count", cnt0, 2);
    check_eq("stream.pop_id", pid0, 11);
    tick();
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);

    // Kill at head.
    step(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'd5);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    check_eq("kill_head.pop_valid", pv0, 0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    check_eq("kill_head.next_valid", pv0, 1);
    check_eq("kill_head.next_id", pid0, 6);
    check_eq("kill_head.count", cnt0, 1);
    tick();
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);

    // Kill on the same cycle as the push.
    step(1'b1, 4'd7, 1'b0, 1'b1, 1'b1, 4'd7);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    check_eq("kill_push.pop_valid", pv0, 0);
    check_eq("kill_push.ft_pop_valid", pv1, 0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    check_eq("kill_push.count", cnt0, 0);
    tick();

    // Fall-through on an empty buffer.
    drive(1'b1, 4'd9, 1'b1, 1'b0, 1'b0, '0);
    check_eq("ft.pop_valid", pv1, 1);
    check_eq("ft.pop_id", pid1, 9);
    check_eq("ft.nonft_pop_valid", pv0, 0);
    tick();
    drive(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, '0);
    check_eq("ft.count_bypassed", cnt1, 0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    check_eq("ft.count_stored", cnt1, 1);
    tick();
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);

    // Randomized traffic with frequent id collisions and varying backpressure.
    for (int n = 0; n < 1500; n++) begin
      int pct;
      pct = ((n / 100) % 3 == 0) ? 20 : (((n / 100) % 3 == 1) ? 85 : 50);
      step($urandom_range(0, 99) < 70, IDW'($urandom_range(0, 3)),
           $urandom_range(0, 99) < pct, $urandom_range(0, 99) < 40,
           $urandom_range(0, 99) < 50, IDW'($urandom_range(0, 3)));
    end

    // Reset in the middle of operation.
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b1, IDW'(i + 1), 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    check_eq("midreset.pre_count", cnt0, 3);
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sz[0] = 0; sz[1] = 0;
    check_eq("midreset.empty", empty0, 1);
    check_eq("midreset.pop_valid", pv0, 0);
    check_eq("midreset.issue_ready", ir0, 1);
    check_eq("midreset.ft_empty", empty1, 1);
    tick();
    @(negedge clk); rst_n = 1'b1;
    drive(1'b1, 4'hA, 1'b0, 1'b0, 1'b0, '0);
    saved = instr;
    tick();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    check_eq("midreset.pop_valid_after", pv0, 1);
    check_eq("midreset.pop_id_after", pid0, 4'hA);
    check_eq("midreset.pop_instr_after", pin0, saved);
    tick();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
